rx_serial_7o1: RTL and testbench

RX_SERIAL_7O1 -- requirements
Module: rx_serial_7o1

---
 rtl/rx_serial_pkg.sv | 28 ++
 rtl/contador_baud.sv | 46 ++++
 rtl/rx_serial_7o1.sv | 179 +++++++++++++++++
 tb/tb_rx_serial_7o1.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_serial_pkg.sv
// Shared state encoding, timing constants and parity helper for the 7O1 serial receiver.
// The macro RX_PARITY_CHECK_EN enables the odd-parity check; without it erro_paridade stays 0.
package rx_serial_pkg;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    ESPERA   = 3'd1,
    CONFIRMA = 3'd2,
    RECEPCAO = 3'd3,
    ARMAZENA = 3'd4,
    FINAL    = 3'd5
  } estado_t;

  localparam int unsigned BAUD_DIV      = 434;
  localparam int unsigned HALF_DIV      = 217;
  localparam int unsigned NUM_DATA_BITS = 7;
  localparam int unsigned NUM_SAMPLES   = 9;
  localparam int unsigned CNT_W         = 9;
  localparam int unsigned SAMPLE_CNT_W  = 4;

`ifdef RX_PARITY_CHECK_EN
  // Odd parity: data bits plus parity bit must carry an odd number of ones.
  function automatic logic erro_paridade_impar(input logic [NUM_DATA_BITS:0] bits);
    return ~(^bits);
  endfunction
`endif

endpackage

// File: rtl/contador_baud.sv
// Half-bit / full-bit timing counter for the serial receiver; restarted by zera,
// advanced by conta, meio selects the half-bit terminal count.
module contador_baud
  import rx_serial_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  input  logic meio,
  output logic tick_meio,
  output logic tick_bit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_meio = conta & meio  & (cnt_q == CNT_W'(HALF_DIV - 1));
  assign tick_bit  = conta & ~meio & (cnt_q == CNT_W'(BAUD_DIV - 1));

  // Next count: wrap on either terminal count so sampling stays phase-locked.
  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta) begin
      if (tick_meio || tick_bit) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 serial receiver (115200 baud at 50 MHz): synchronizer, FSM, shift register, status flags.
// Define RX_PARITY_CHECK_EN to enable the odd-parity check on erro_paridade.
module rx_serial_7o1
  import rx_serial_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  input  logic       limpa,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_frame,
  output logic       erro_overrun,
  output logic [3:0] db_estado
);

  estado_t                   state_q, state_d;
  logic                      sync1_q, sync2_q, prev_q;
  logic [SAMPLE_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [NUM_SAMPLES-1:0]    shift_q, shift_d;
  logic [NUM_DATA_BITS-1:0]  dados_q, dados_d;
  logic                      pronto_q, pronto_d;
  logic                      tem_dado_q, tem_dado_d;
  logic                      erro_frame_q, erro_frame_d;
  logic                      overrun_q, overrun_d;
  logic                      zera, conta, meio, tick_meio, tick_bit;
  logic                      queda;
`ifdef RX_PARITY_CHECK_EN
  logic                      erro_par_q, erro_par_d;
`endif

  contador_baud u_contador_baud (
    .clock     (clock),
    .reset     (reset),
    .zera      (zera),
    .conta     (conta),
    .meio      (meio),
    .tick_meio (tick_meio),
    .tick_bit  (tick_bit)
  );

  // Only a 1->0 transition of the synchronized line may start a frame.
  assign queda = prev_q & ~sync2_q;

  // Line synchronizer and edge-detect history; idle level is 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= dado_serial;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next-state, datapath and flag logic.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    dados_d      = dados_q;
    erro_frame_d = erro_frame_q;
    tem_dado_d   = tem_dado_q;
    overrun_d    = overrun_q;
    zera         = 1'b0;
    conta        = 1'b0;
    meio         = 1'b0;
    pronto_d     = (state_q == ARMAZENA);
`ifdef RX_PARITY_CHECK_EN
    erro_par_d   = erro_par_q;
`endif
    if (limpa) begin
      tem_dado_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      tem_dado_d = tem_dado_q;
      overrun_d  = overrun_q;
    end
    case (state_q)
      INICIAL: begin
        zera    = 1'b1;
        state_d = ESPERA;
      end
      ESPERA: begin
        zera = 1'b1;
        if (queda) state_d = CONFIRMA;
        else       state_d = ESPERA;
      end
      CONFIRMA: begin
        conta     = 1'b1;
        meio      = 1'b1;
        bit_cnt_d = '0;
        if (tick_meio) begin
          if (!sync2_q) state_d = RECEPCAO;
          else          state_d = ESPERA;
        end else begin
          state_d = CONFIRMA;
        end
      end
      RECEPCAO: begin
        conta = 1'b1;
        if (tick_bit) begin
          shift_d   = {sync2_q, shift_q[NUM_SAMPLES-1:1]};
          bit_cnt_d = bit_cnt_q + SAMPLE_CNT_W'(1);
          if (bit_cnt_q == SAMPLE_CNT_W'(NUM_SAMPLES - 1)) state_d = ARMAZENA;
          else                                             state_d = RECEPCAO;
        end else begin
          state_d = RECEPCAO;
        end
      end
      ARMAZENA: begin
        dados_d      = shift_q[NUM_DATA_BITS-1:0];
        erro_frame_d = ~shift_q[NUM_SAMPLES-1];
`ifdef RX_PARITY_CHECK_EN
        erro_par_d   = erro_paridade_impar(shift_q[NUM_DATA_BITS:0]);
`endif
        state_d      = FINAL;
      end
      FINAL: begin
        // A coincident acknowledge keeps the new character but drops the overrun.
        tem_dado_d = 1'b1;
        overrun_d  = ~limpa & (overrun_q | tem_dado_q);
        state_d    = ESPERA;
      end
      default: begin
        state_d = INICIAL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= INICIAL;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      dados_q      <= '0;
      pronto_q     <= 1'b0;
      tem_dado_q   <= 1'b0;
      erro_frame_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      dados_q      <= dados_d;
      pronto_q     <= pronto_d;
      tem_dado_q   <= tem_dado_d;
      erro_frame_q <= erro_frame_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef RX_PARITY_CHECK_EN
  // Parity status register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      erro_par_q <= 1'b0;
    end else begin
      erro_par_q <= erro_par_d;
    end
  end
  assign erro_paridade = erro_par_q;
`else
  assign erro_paridade = 1'b0;
`endif

  assign dados_ascii  = dados_q;
  assign pronto       = pronto_q;
  assign tem_dado     = tem_dado_q;
  assign erro_frame   = erro_frame_q;
  assign erro_overrun = overrun_q;
  assign db_estado    = {1'b0, state_q};

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Directed self-checking bench for rx_serial_7o1: frames are driven bit by bit on the
// serial line and every output is compared against hand-computed values.
module tb_rx_serial_7o1;

  logic       clock;
  logic       reset;
  logic       dado_serial;
  logic       limpa;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_frame;
  logic       erro_overrun;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pronto_cnt = 0;
  int last_pronto_cyc = 0;
  int exp_pronto = 0;
  int budget;

`ifdef RX_PARITY_CHECK_EN
  localparam logic PAR_ON = 1'b1;
`else
  localparam logic PAR_ON = 1'b0;
`endif

  rx_serial_7o1 dut (
    .clock         (clock),
    .reset         (reset),
    .dado_serial   (dado_serial),
    .limpa         (limpa),
    .dados_ascii   (dados_ascii),
    .pronto        (pronto),
    .tem_dado      (tem_dado),
    .erro_paridade (erro_paridade),
    .erro_frame    (erro_frame),
    .erro_overrun  (erro_overrun),
    .db_estado     (db_estado)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pronto) begin
      pronto_cnt      <= pronto_cnt + 1;
      last_pronto_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives idle, start bit and frame bits 1..nbits; returns right after driving bit nbits.
  task automatic send_frame(input logic [6:0] d, input logic par, input logic stp, input int nbits);
    logic [9:0] fr;
    fr = {stp, par, d, 1'b0};
    @(negedge clock);
    dado_serial = 1'b1;
    repeat (10) @(negedge clock);
    dado_serial = 1'b0;
    start_cyc   = cyc;
    for (int k = 1; k <= nbits; k++) begin
      repeat (434) @(negedge clock);
      dado_serial = fr[k];
    end
  endtask

  task automatic pulse_limpa();
    @(negedge clock);
    limpa = 1'b1;
    @(negedge clock);
    limpa = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    reset       = 1'b0;
    dado_serial = 1'b1;
    limpa       = 1'b0;
    repeat (3) @(negedge clock);

    check("rst_estado",   db_estado, 4'd0);
    check("rst_dados",    dados_ascii, 7'h00);
    check("rst_pronto",   pronto, 1'b0);
    check("rst_tem_dado", tem_dado, 1'b0);
    check("rst_flags",    {erro_paridade, erro_frame, erro_overrun}, 3'b000);

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_estado", db_estado, 4'd1);

    // 0x41 with correct odd parity and good stop bit
    send_frame(7'h41, 1'b1, 1'b1, 9);
    repeat (440) @(negedge clock);
    exp_pronto++;
    check("f1_dados",      dados_ascii, 7'h41);
    check("f1_par",        erro_paridade, 1'b0);
    check("f1_frame",      erro_frame, 1'b0);
    check("f1_tem_dado",   tem_dado, 1'b1);
    check("f1_overrun",    erro_overrun, 1'b0);
    check("f1_pronto_cnt", pronto_cnt, exp_pronto);
    check("f1_pronto_lat", last_pronto_cyc - start_cyc, 4127);
    pulse_limpa();
    check("f1_limpa_tem_dado", tem_dado, 1'b0);

    // 0x41 with wrong parity bit
    send_frame(7'h41, 1'b0, 1'b1, 9);
    repeat (440) @(negedge clock);
    exp_pronto++;
    check("f2_dados",      dados_ascii, 7'h41);
    check("f2_par",        erro_paridade, PAR_ON);
    check("f2_frame",      erro_frame, 1'b0);
    check("f2_pronto_cnt", pronto_cnt, exp_pronto);
    pulse_limpa();

    // 0x35 with good parity but stop bit 0; line stays low afterwards
    send_frame(7'h35, 1'b1, 1'b0, 9);
    repeat (440) @(negedge clock);
    exp_pronto++;
    check("f3_dados",      dados_ascii, 7'h35);
    check("f3_frame",      erro_frame, 1'b1);
    check("f3_par",        erro_paridade, 1'b0);
    check("f3_pronto_cnt", pronto_cnt, exp_pronto);
    check("f3_low_estado", db_estado, 4'd1);
    pulse_limpa();

    // 100-cycle low glitch on an idle line
    dado_serial = 1'b1;
    repeat (20) @(negedge clock);
    dado_serial = 1'b0;
    repeat (100) @(negedge clock);
    check("gl_confirma", db_estado, 4'd2);
    dado_serial = 1'b1;
    repeat (300) @(negedge clock);
    check("gl_estado",     db_estado, 4'd1);
    check("gl_pronto_cnt", pronto_cnt, exp_pronto);
    check("gl_dados",      dados_ascii, 7'h35);

    // 0x41 then 0x42 without acknowledge
    send_frame(7'h41, 1'b1, 1'b1, 9);
    repeat (440) @(negedge clock);
    check("ov1_overrun", erro_overrun, 1'b0);
    send_frame(7'h42, 1'b1, 1'b1, 9);
    repeat (440) @(negedge clock);
    exp_pronto += 2;
    check("ov2_overrun",    erro_overrun, 1'b1);
    check("ov2_dados",      dados_ascii, 7'h42);
    check("ov2_tem_dado",   tem_dado, 1'b1);
    check("ov2_pronto_cnt", pronto_cnt, exp_pronto);
    pulse_limpa();
    check("ov_limpa_tem_dado", tem_dado, 1'b0);
    check("ov_limpa_overrun",  erro_overrun, 1'b0);

    // Acknowledge coinciding with FINAL while a character is already held
    send_frame(7'h30, 1'b1, 1'b1, 9);
    repeat (440) @(negedge clock);
    send_frame(7'h31, 1'b0, 1'b1, 9);
    budget = 0;
    while (!pronto && budget < 1000) begin
      @(negedge clock);
      budget++;
    end
    check("co_pronto_seen", pronto, 1'b1);
    limpa = 1'b1;
    @(negedge clock);
    limpa = 1'b0;
    repeat (5) @(negedge clock);
    exp_pronto += 2;
    check("co_tem_dado",   tem_dado, 1'b1);
    check("co_overrun",    erro_overrun, 1'b0);
    check("co_dados",      dados_ascii, 7'h31);
    check("co_pronto_cnt", pronto_cnt, exp_pronto);

    // Reset during data bit 3, then a clean 0x7A
    send_frame(7'h55, 1'b1, 1'b1, 4);
    repeat (200) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("mr_estado",   db_estado, 4'd0);
    check("mr_tem_dado", tem_dado, 1'b0);
    check("mr_dados",    dados_ascii, 7'h00);
    dado_serial = 1'b1;
    reset = 1'b1;
    repeat (5000) @(negedge clock);
    check("mr_pronto_cnt", pronto_cnt, exp_pronto);
    send_frame(7'h7A, 1'b0, 1'b1, 9);
    repeat (440) @(negedge clock);
    exp_pronto++;
    check("f7a_dados",      dados_ascii, 7'h7A);
    check("f7a_par",        erro_paridade, 1'b0);
    check("f7a_frame",      erro_frame, 1'b0);
    check("f7a_pronto_cnt", pronto_cnt, exp_pronto);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
